// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// - Parity mode constants PAR_NONE / PAR_ODD / PAR_EVEN.
// - rx_state_t: receiver FSM state encoding.
// - cnt_width(): width of the per-bit cycle counter for a given CYCLE.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    function automatic int unsigned cnt_width(input int unsigned cycle);
        return (cycle > 1) ? $clog2(cycle) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and data
//   pop             read request (ignored while empty)
//   pop_data        head entry, valid whenever empty=0
//   full, empty     occupancy flags
//   count           number of occupied entries
//   drop            a push was refused because the FIFO was full with no pop
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees the slot the simultaneous push writes into, so full+pop still accepts.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with majority-vote sampling, false-start rejection,
// parity/stop error flags and a FWFT output FIFO drained over valid/ready.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   rx               serial line (asynchronous)
//   enable           receiver enable; low aborts any frame in progress
//   rx_data          head entry data
//   rx_frame_err     head entry stop-bit error
//   rx_parity_err    head entry parity error
//   rx_data_valid    FIFO not empty
//   rx_data_ready    consumer accepts head entry
//   overrun          sticky: a word was dropped on a full FIFO
//   overrun_clr      clears overrun (a same-cycle new overrun wins)
//   fifo_count       occupied entries
//   rx_busy          frame reception in progress
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          enable,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_data_valid,
    input  logic                          rx_data_ready,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy
);

    localparam int unsigned CYCLE = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF  = CYCLE / 2;
    localparam int unsigned CW    = cnt_width(CYCLE);
    localparam int unsigned WIDTH = DATA_BITS + 2;

    localparam logic [CW-1:0] CntPre    = CW'(HALF - 1);
    localparam logic [CW-1:0] CntMid    = CW'(HALF);
    localparam logic [CW-1:0] CntDecide = CW'(HALF + 1);
    localparam logic [CW-1:0] CntLast   = CW'(CYCLE - 1);
    localparam logic [3:0]    LastBit   = 4'(DATA_BITS - 1);
    localparam logic          StopLast  = 1'(STOP_BITS - 1);

    // Synchroniser and edge detect
    logic rx_meta_q, rxs_q, rxs_prev_q;
    logic fall_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign fall_edge = rxs_prev_q & ~rxs_q;

    // Receiver state
    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frame_err_q;
    logic                 samp_a_q, samp_b_q;
    logic                 vote;
    logic                 at_decide, at_end;
    logic                 par_calc;
    logic                 push;
    logic [WIDTH-1:0]     push_word;

    // First two vote samples; the third is rxs itself at the decision count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_a_q <= 1'b1;
            samp_b_q <= 1'b1;
        end else begin
            if (cnt_q == CntPre) samp_a_q <= rxs_q;
            if (cnt_q == CntMid) samp_b_q <= rxs_q;
        end
    end

    assign vote      = (samp_a_q & samp_b_q) | (samp_a_q & rxs_q) | (samp_b_q & rxs_q);
    assign at_decide = (cnt_q == CntDecide);
    assign at_end    = (cnt_q == CntLast);

    always_comb begin
        par_calc = 1'b0;
        if (PARITY == PAR_ODD) begin
            par_calc = ~(^shift_q ^ vote);
        end else if (PARITY == PAR_EVEN) begin
            par_calc = ^shift_q ^ vote;
        end
    end

    assign push = enable && (state_q == StStop) && at_decide && (stop_idx_q == StopLast);
    assign push_word = {par_err_q, frame_err_q | ~vote, shift_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (!enable) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (fall_edge) begin
                        state_q     <= StStart;
                        bit_idx_q   <= '0;
                        stop_idx_q  <= 1'b0;
                        par_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (at_decide && vote) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (at_end) begin
                        state_q <= StData;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (at_decide) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                    if (at_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == LastBit) begin
                            state_q <= (PARITY == PAR_NONE) ? StStop : StParity;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (at_decide) par_err_q <= par_calc;
                    if (at_end) begin
                        state_q <= StStop;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (at_decide && stop_idx_q == StopLast) begin
                        // Leave mid-bit; a start edge already seen here begins the next frame.
                        cnt_q <= '0;
                        if (fall_edge) begin
                            state_q     <= StStart;
                            bit_idx_q   <= '0;
                            stop_idx_q  <= 1'b0;
                            par_err_q   <= 1'b0;
                            frame_err_q <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (at_decide) begin
                        if (!vote) frame_err_q <= 1'b1;
                        cnt_q <= cnt_q + 1'b1;
                    end else if (at_end) begin
                        stop_idx_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_busy = (state_q != StIdle);

    // Output FIFO
    logic [WIDTH-1:0] head;
    logic             fifo_full, fifo_empty, fifo_drop, pop;
    logic             overrun_q;

    assign pop = rx_data_valid & rx_data_ready;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (fifo_drop) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun       = overrun_q;
    assign rx_data_valid = ~fifo_empty;
    // Storage is not reset, so mask the head while empty to present zeros.
    assign rx_data       = rx_data_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_frame_err  = rx_data_valid & head[DATA_BITS];
    assign rx_parity_err = rx_data_valid & head[DATA_BITS+1];

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. Instance A: 8N1, 4-entry FIFO.
// Instance B: 7 data bits, even parity, 2 stop bits, 16-entry FIFO. CYCLE = 10.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rx_a = 1'b1, en_a = 1'b1, rdy_a = 1'b0, clr_a = 1'b0;
    logic [7:0] data_a;
    logic       ferr_a, perr_a, valid_a, ovr_a, busy_a;
    logic [2:0] cnt_a;

    logic       rx_b = 1'b1, en_b = 1'b1, rdy_b = 1'b0, clr_b = 1'b0;
    logic [6:0] data_b;
    logic       ferr_b, perr_b, valid_b, ovr_b, busy_b;
    logic [4:0] cnt_b;

    uart_rx_fifo #(
        .CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .enable(en_a), .rx_data(data_a),
        .rx_frame_err(ferr_a), .rx_parity_err(perr_a), .rx_data_valid(valid_a),
        .rx_data_ready(rdy_a), .overrun(ovr_a), .overrun_clr(clr_a),
        .fifo_count(cnt_a), .rx_busy(busy_a)
    );

    uart_rx_fifo #(
        .CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .enable(en_b), .rx_data(data_b),
        .rx_frame_err(ferr_b), .rx_parity_err(perr_b), .rx_data_valid(valid_b),
        .rx_data_ready(rdy_b), .overrun(ovr_b), .overrun_clr(clr_b),
        .fifo_count(cnt_b), .rx_busy(busy_b)
    );

    int errors = 0;
    int checks = 0;

    // Popped words from instance A: {parity_err, frame_err, data}
    logic       mon_en = 1'b0;
    logic [9:0] got_q[$];
    always @(negedge clk) begin
        if (mon_en && valid_a && rdy_a) got_q.push_back({perr_a, ferr_a, data_a});
    end

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // par_bit < 0 means no parity bit.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input int par_bit, input int nstop, input logic stop_val,
                              input int bit_t);
        drive(sel, 1'b0);
        #(bit_t);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, data[i]);
            #(bit_t);
        end
        if (par_bit >= 0) begin
            drive(sel, par_bit[0]);
            #(bit_t);
        end
        for (int s = 0; s < nstop; s++) begin
            drive(sel, stop_val);
            #(bit_t);
        end
        drive(sel, 1'b1);
    endtask

    task automatic pop_a;
        @(negedge clk) rdy_a = 1'b1;
        @(negedge clk) rdy_a = 1'b0;
    endtask

    task automatic pop_b;
        @(negedge clk) rdy_b = 1'b1;
        @(negedge clk) rdy_b = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt_a); end
        checks++; if ({ovr_a, busy_a, ferr_a, perr_a} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {ovr_a, busy_a, ferr_a, perr_a}); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({valid_a, busy_a, valid_b, busy_b} !== 4'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0000", {valid_a, busy_a, valid_b, busy_b}); end
    endtask

    task automatic test_8n1;
        @(negedge clk);
        send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, 100);
        repeat (3) @(negedge clk);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL 8n1_valid got=%b exp=1", valid_a); end
        checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL 8n1_data got=%h exp=a5", data_a); end
        checks++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL 8n1_err got=%b exp=00", {perr_a, ferr_a}); end
        checks++; if (cnt_a !== 3'd1) begin errors++; $display("FAIL 8n1_count got=%0d exp=1", cnt_a); end
        pop_a();
        checks++; if ({cnt_a, valid_a} !== 4'b0000) begin errors++; $display("FAIL 8n1_pop got cnt=%0d valid=%b exp 0/0", cnt_a, valid_a); end
    endtask

    task automatic test_parity;
        // 0x55 in 7 bits has four ones, so the even parity bit is 0.
        @(negedge clk);
        send_frame(1, 9'h055, 7, 0, 2, 1'b1, 100);
        repeat (3) @(negedge clk);
        checks++; if ({valid_b, data_b} !== {1'b1, 7'h55}) begin errors++; $display("FAIL 7e2_data got=%b/%h exp=1/55", valid_b, data_b); end
        checks++; if ({perr_b, ferr_b} !== 2'b00) begin errors++; $display("FAIL 7e2_err got=%b exp=00", {perr_b, ferr_b}); end
        pop_b();
        @(negedge clk);
        send_frame(1, 9'h055, 7, 1, 2, 1'b1, 100);
        repeat (3) @(negedge clk);
        checks++; if ({valid_b, data_b} !== {1'b1, 7'h55}) begin errors++; $display("FAIL 7e2_bad_data got=%b/%h exp=1/55", valid_b, data_b); end
        checks++; if ({perr_b, ferr_b} !== 2'b10) begin errors++; $display("FAIL 7e2_perr got=%b exp=10", {perr_b, ferr_b}); end
        pop_b();
        checks++; if (cnt_b !== 5'd0) begin errors++; $display("FAIL 7e2_drain got=%0d exp=0", cnt_b); end
    endtask

    task automatic test_framing;
        int  waited;
        logic seen;
        @(negedge clk);
        send_frame(0, 9'h03C, 8, -1, 1, 1'b0, 100);
        repeat (3) @(negedge clk);
        checks++; if ({valid_a, data_a} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL ferr_data got=%b/%h exp=1/3c", valid_a, data_a); end
        checks++; if ({perr_a, ferr_a} !== 2'b01) begin errors++; $display("FAIL ferr_flag got=%b exp=01", {perr_a, ferr_a}); end
        pop_a();
        // 3-clock glitch: must be seen as a start and then rejected
        repeat (20) @(negedge clk);
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        seen = 1'b0;
        waited = 0;
        while (waited < 10) begin
            @(negedge clk);
            waited++;
            if (busy_a) seen = 1'b1;
            if (seen && !busy_a) break;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b exp=1", seen); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy=%b after %0d clocks exp=0", busy_a, waited); end
        repeat (20) @(negedge clk);
        checks++; if ({valid_a, cnt_a} !== 4'b0) begin errors++; $display("FAIL glitch_nopush got valid=%b cnt=%0d exp 0/0", valid_a, cnt_a); end
    endtask

    task automatic test_overrun;
        logic [7:0] w;
        for (int i = 1; i <= 5; i++) begin
            w = 8'(i * 8'h11);
            @(negedge clk);
            send_frame(0, {1'b0, w}, 8, -1, 1, 1'b1, 100);
            #200;
        end
        checks++; if (cnt_a !== 3'd4) begin errors++; $display("FAIL ovr_count got=%0d exp=4", cnt_a); end
        checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", ovr_a); end
        checks++; if (data_a !== 8'h11) begin errors++; $display("FAIL ovr_head got=%h exp=11", data_a); end
        @(negedge clk) clr_a = 1'b1;
        @(negedge clk) clr_a = 1'b0;
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", ovr_a); end
        for (int i = 1; i <= 4; i++) begin
            w = 8'(i * 8'h11);
            checks++; if (data_a !== w) begin errors++; $display("FAIL ovr_drain%0d got=%h exp=%h", i, data_a, w); end
            pop_a();
        end
        // Fill again, then pop in the very cycle of the fifth push.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            send_frame(0, 9'(8'h60 + i), 8, -1, 1, 1'b1, 100);
            #200;
        end
        @(negedge clk);
        fork
            send_frame(0, 9'h065, 8, -1, 1, 1'b1, 100);
            begin
                repeat (99) @(negedge clk);
                rdy_a = 1'b1;
                @(negedge clk) rdy_a = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        checks++; if (cnt_a !== 3'd4) begin errors++; $display("FAIL ovr_pp_count got=%0d exp=4", cnt_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_pp_flag got=%b exp=0", ovr_a); end
        for (int i = 2; i <= 5; i++) begin
            w = 8'(8'h60 + i);
            checks++; if (data_a !== w) begin errors++; $display("FAIL ovr_pp_drain%0d got=%h exp=%h", i, data_a, w); end
            pop_a();
        end
    endtask

    task automatic test_disable_reset;
        @(negedge clk);
        fork
            send_frame(0, 9'h077, 8, -1, 1, 1'b1, 100);
            begin
                repeat (45) @(negedge clk);
                checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL dis_busy_before got=%b exp=1", busy_a); end
                en_a = 1'b0;
                @(negedge clk);
                checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL dis_idle got=%b exp=0", busy_a); end
            end
        join
        #300;
        en_a = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if ({valid_a, cnt_a} !== 4'b0) begin errors++; $display("FAIL dis_nopush got valid=%b cnt=%0d exp 0/0", valid_a, cnt_a); end
        // Leave one word queued so reset has something to clear.
        @(negedge clk);
        send_frame(0, 9'h05A, 8, -1, 1, 1'b1, 100);
        repeat (3) @(negedge clk);
        checks++; if ({cnt_a, data_a} !== {3'd1, 8'h5A}) begin errors++; $display("FAIL rst_pre got cnt=%0d data=%h exp 1/5a", cnt_a, data_a); end
        @(negedge clk);
        fork
            send_frame(0, 9'h0FF, 8, -1, 1, 1'b1, 100);
            begin
                repeat (42) @(negedge clk);
                rst = 1'b1;
                #1;
                checks++; if ({valid_a, cnt_a, data_a, busy_a, ovr_a, ferr_a, perr_a} !== 15'b0) begin
                    errors++;
                    $display("FAIL rst_mid got valid=%b cnt=%0d data=%h busy=%b ovr=%b", valid_a, cnt_a, data_a, busy_a, ovr_a);
                end
                @(negedge clk) rst = 1'b0;
            end
        join
        #300;
        @(negedge clk);
        send_frame(0, 9'h0C3, 8, -1, 1, 1'b1, 100);
        repeat (3) @(negedge clk);
        checks++; if ({cnt_a, data_a, ferr_a} !== {3'd1, 8'hC3, 1'b0}) begin errors++; $display("FAIL rst_after got cnt=%0d data=%h ferr=%b exp 1/c3/0", cnt_a, data_a, ferr_a); end
        pop_a();
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [16];
        words = '{8'h3A, 8'hC5, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'hED,
                  8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h96, 8'h69, 8'h01, 8'h80};
        got_q.delete();
        rdy_a = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            send_frame(0, {1'b0, words[i]}, 8, -1, 1, 1'b1, (i < 8) ? 97 : 103);
        end
        repeat (30) @(negedge clk);
        mon_en = 1'b0;
        rdy_a = 1'b0;
        checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < 16; i++) begin
            if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== {2'b00, words[i]}) begin
                    errors++;
                    $display("FAIL b2b_word%0d got=%h exp=%h", i, got_q[i], {2'b00, words[i]});
                end
            end
        end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", ovr_a); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_overrun();
        test_disable_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver: the successor to the fixed 8N1 receiver. It adds configurable data width, parity and stop bits, an input synchroniser, majority-vote sampling, false-start rejection and error flags. Received words go into an internal FIFO and leave through a valid/ready stream interface, so software or a DMA engine can drain them at its own pace. It sits between the `rx` pad and the core's peripheral bus.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate. `CYCLE = CLK_FREQ/BAUD_RATE`, which must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: number of entries, a power of two, ≥ 2.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `rx`  in  1  serial line, asynchronous to `clk`.
- `enable`  in  1  receiver enable.
- `rx_data`  out  DATA_BITS  data of the FIFO head entry.
- `rx_frame_err`  out  1  stop-bit error flag of the head entry.
- `rx_parity_err`  out  1  parity error flag of the head entry.
- `rx_data_valid`  out  1  FIFO not empty.
- `rx_data_ready`  in  1  consumer accepts the head entry.
- `overrun`  out  1  sticky: a word was dropped because the FIFO was full.
- `overrun_clr`  in  1  clears `overrun`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `rx_busy`  out  1  a frame is being received (state ≠ IDLE).

## Operation
**Synchroniser**
- `rx` passes through 2 flops, both reset to 1, giving `rxs`.
- A further flop on `rxs` provides falling-edge detection.

**State machine** (states IDLE, START, DATA, PARITY, STOP)
- A cycle counter runs 0..CYCLE-1 and clears on every state change.
- The sample point is count `CYCLE/2`. The sampled bit is the majority of `rxs` at counts `CYCLE/2-1`, `CYCLE/2` and `CYCLE/2+1`, and the decision is taken at `CYCLE/2+1`.
- IDLE: a falling edge of `rxs` with `enable=1` moves to START.
- START: if the voted bit is 1, it is a false start and the FSM returns to IDLE with nothing pushed. Otherwise it moves to DATA at count CYCLE-1.
- DATA: shifts in DATA_BITS bits, LSB first, one per bit period. After the last bit it goes to PARITY, or to STOP when `PARITY=0`.
- PARITY: `parity_err` is 1 when the XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode). Always 0 when `PARITY=0`.
- STOP: samples STOP_BITS stop bits. `frame_err` is 1 if any stop bit votes 0.
  - At the decision point of the last stop bit, the entry {parity_err, frame_err, data} is pushed and the FSM returns to IDLE in the same cycle.
  - Returning mid-bit allows back-to-back frames; the next start edge resynchronises.
- `enable` low forces IDLE on the next clock. Any partial frame is discarded. FIFO contents and `overrun` are kept.

**FIFO**
- First-word-fall-through: the head entry is always on the outputs whenever `rx_data_valid=1`.
- Pop occurs when `rx_data_valid && rx_data_ready`. `rx_data_ready` is ignored while the FIFO is empty.
- Push while full without a pop in the same cycle: the word is dropped, FIFO contents are unchanged, and `overrun` sets.
- Push while full with a pop in the same cycle: both take effect, and the count stays at FIFO_DEPTH.
- Push while empty: the entry is visible on the next cycle.
- `overrun_clr` and a new overrun in the same cycle: `overrun` stays 1 (set wins).
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.

## Timing
Reset values:
- `rx_data`, `rx_frame_err`, `rx_parity_err`, `rx_data_valid`, `overrun` and `rx_busy` = 0.
- `fifo_count` = 0.
- FSM = IDLE, synchroniser = 1.

Latencies:
- The `rx` falling edge reaches the FSM 3 clocks later (2 synchroniser flops plus the edge flop).
- The push occurs at `CYCLE/2+1` into the last stop bit.
- `rx_data_valid` rises 1 clock after a push into an empty FIFO.
- After a pop, `fifo_count` and the head outputs update on the next clock.

## Structure
- Package `uart_pkg`:
  - parity mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the `rx_state_t` enum;
  - a helper for the counter width, `$clog2(CYCLE)`.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - push/pop with full/empty/count outputs;
  - asynchronous reset;
  - reusable by the future `uart_tx_fifo`.
- Instantiated with `WIDTH = DATA_BITS+2`.

## Test plan
All scenarios use CLK_FREQ=100_000_000 and BAUD_RATE=10_000_000, so CYCLE=10.
- **8N1 frame:** send 0xA5 → one entry, `rx_data=0xA5`, both error flags 0, `fifo_count=1`; popping it returns the count to 0.
- **7 bits, even parity, 2 stop bits:** send 0x55 with a correct parity bit → err=0. Send 0x55 with the parity bit flipped → `rx_parity_err=1`.
- **Framing and glitches:** a stop bit held at 0 → `rx_frame_err=1`, data still captured. A 3-clock low glitch on an idle line → no push, `rx_busy` back to 0 within CYCLE clocks.
- **Overrun:** with `FIFO_DEPTH=4` and `rx_data_ready=0`, send 5 frames → `fifo_count=4`, `overrun=1`, head = frame 1. With a pop in the same cycle as the 5th push, 4 entries remain and `overrun=0`.
- **Disable and reset mid-frame:** drop `enable` during bit 3 → no push, IDLE on the next clock. Assert `rst` mid-frame → all outputs at reset values, and the next frame is received correctly.
- **Back-to-back frames:** 16 random words with no idle gap, with ±3 % baud error on the stimulus → all words received in order, no errors.
